// File: rtl/alu_exec_seq.sv
// alu_exec_seq: ALU command sequencer that sits after the alu_regs register file.
// Each accepted command reads two operands through the register file read selects
// and runs either a single-cycle op or a DATA_W-step shift-add multiply. The result
// goes back through the write port, and ZNCV flags update at write-back.
module alu_exec_seq #(
    parameter int DATA_W    = 8,
    parameter int NREG_BITS = 3,
    parameter int WSEL_W    = 7,
    parameter int MUL_EN    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [NREG_BITS-1:0] cmd_dst,
    input  logic [NREG_BITS-1:0] cmd_src_a,
    input  logic [NREG_BITS-1:0] cmd_src_b,
    output logic [NREG_BITS-1:0] rd_slct_a,
    output logic [NREG_BITS-1:0] rd_slct_b,
    input  logic [DATA_W-1:0]    data_out_a,
    input  logic [DATA_W-1:0]    data_out_b,
    output logic [DATA_W-1:0]    data_in,
    output logic [WSEL_W-1:0]    wrt_slct,
    output logic                 wrtnbl,
    output logic [3:0]           flags,
    output logic                 done
);

    localparam int               CW   = $clog2(DATA_W);
    localparam logic [CW-1:0]    LAST = CW'(DATA_W - 1);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_MUL  = 4'd8;
    localparam logic [3:0] OP_PASS = 4'd9;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

    typedef struct packed {
        logic [3:0]           op;
        logic [NREG_BITS-1:0] dst;
    } cmd_t;

    state_t                state, state_nxt;
    cmd_t                  cmd_q;
    logic [DATA_W-1:0]     a_q, b_q;
    logic [2*DATA_W-1:0]   acc, mcand, acc_step;
    logic [DATA_W-1:0]     mplier;
    logic [CW-1:0]         cnt;
    logic [3:0]            flags_pend;

    logic                  legal, is_mul, exec_last;
    logic [DATA_W:0]       sum, diff;
    logic [DATA_W-1:0]     res;
    logic                  res_c, res_v;
    logic [3:0]            flags_new;

    // A multiply is legal only when the multiplier is built in; opcodes past PASS never are.
    assign is_mul    = (cmd_q.op == OP_MUL) && (MUL_EN != 0);
    assign legal     = (cmd_q.op <= OP_PASS) && ((cmd_q.op != OP_MUL) || (MUL_EN != 0));
    assign exec_last = !is_mul || (cnt == LAST);

    // State register; reset aborts any in-flight command before its write-back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake/write-back strobes.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        wrtnbl    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = S_READ;
            end
            S_READ: state_nxt = S_EXEC;
            S_EXEC: if (exec_last) state_nxt = S_WB;
            S_WB: begin
                wrtnbl    = legal;
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result and flag computation. The MUL result is taken from the final accumulate step.
    always_comb begin
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = {1'b0, a_q} - {1'b0, b_q};
        acc_step = acc + (mplier[0] ? mcand : '0);
        res      = '0;
        res_c    = 1'b0;
        res_v    = 1'b0;
        case (cmd_q.op)
            OP_ADD: begin
                res   = sum[DATA_W-1:0];
                res_c = sum[DATA_W];
                res_v = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (sum[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_SUB: begin
                res   = diff[DATA_W-1:0];
                res_c = diff[DATA_W];
                res_v = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (diff[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_AND:  res = a_q & b_q;
            OP_OR:   res = a_q | b_q;
            OP_XOR:  res = a_q ^ b_q;
            OP_NOT:  res = ~a_q;
            OP_SHL: begin
                res   = {a_q[DATA_W-2:0], 1'b0};
                res_c = a_q[DATA_W-1];
            end
            OP_SHR: begin
                res   = {1'b0, a_q[DATA_W-1:1]};
                res_c = a_q[0];
            end
            OP_MUL: begin
                res   = acc_step[DATA_W-1:0];
                res_c = |acc_step[2*DATA_W-1:DATA_W];
            end
            OP_PASS: res = a_q;
            default: res = '0;
        endcase
        flags_new = {(res == '0), res[DATA_W-1], res_c, res_v};
    end

    // Datapath: latch the command and operands, step the multiplier, stage write-back and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= '0;
            rd_slct_a  <= '0;
            rd_slct_b  <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            data_in    <= '0;
            wrt_slct   <= '0;
            flags_pend <= '0;
            flags      <= '0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    cmd_q     <= '{op: cmd_op, dst: cmd_dst};
                    rd_slct_a <= cmd_src_a;
                    rd_slct_b <= cmd_src_b;
                end
                S_READ: begin
                    a_q    <= data_out_a;
                    b_q    <= data_out_b;
                    acc    <= '0;
                    mcand  <= {{DATA_W{1'b0}}, data_out_a};
                    mplier <= data_out_b;
                    cnt    <= '0;
                end
                S_EXEC: begin
                    if (is_mul) begin
                        acc    <= acc_step;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                    if (exec_last && legal) begin
                        data_in    <= res;
                        wrt_slct   <= {{(WSEL_W-NREG_BITS){1'b0}}, cmd_q.dst};
                        flags_pend <= flags_new;
                    end
                end
                S_WB: if (legal) flags <= flags_pend;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: directed bench with a register-file model and a result scoreboard.
module tb_alu_exec_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready;
    logic [3:0] cmd_op;
    logic [2:0] cmd_dst, cmd_src_a, cmd_src_b;
    logic [2:0] rd_slct_a, rd_slct_b;
    logic [7:0] data_out_a, data_out_b, data_in;
    logic [6:0] wrt_slct;
    logic       wrtnbl, done;
    logic [3:0] flags;

    // register file model plus bench preload port
    logic [7:0] regs [8];
    logic       pre_we;
    logic [2:0] pre_addr;
    logic [7:0] pre_data;

    typedef struct {
        logic [2:0] dst, sa, sb;
        bit         legal;
        logic [7:0] res;
        logic [3:0] fl;
        int         wbk;
    } exp_t;

    exp_t       sbq [$];
    logic [7:0] shadow [8];
    logic [3:0] exp_flags;
    int         n_chk = 0, n_pass = 0;

    logic [3:0] t_op  [10] = '{4'd4, 4'd6, 4'd7, 4'd5, 4'd2, 4'd3, 4'd0, 4'd1, 4'd8, 4'd8};
    logic [2:0] t_dst [10] = '{3'd0, 3'd3, 3'd5, 3'd1, 3'd2, 3'd0, 3'd6, 3'd4, 3'd5, 3'd3};
    logic [2:0] t_sa  [10] = '{3'd1, 3'd3, 3'd6, 3'd5, 3'd6, 3'd4, 3'd6, 3'd3, 3'd6, 3'd0};
    logic [2:0] t_sb  [10] = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd1, 3'd5, 3'd6, 3'd5, 3'd6, 3'd2};

    alu_exec_seq #(.DATA_W(8), .NREG_BITS(3), .WSEL_W(7), .MUL_EN(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_dst(cmd_dst), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b),
        .rd_slct_a(rd_slct_a), .rd_slct_b(rd_slct_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .data_in(data_in), .wrt_slct(wrt_slct), .wrtnbl(wrtnbl),
        .flags(flags), .done(done)
    );

    always #5 clk = ~clk;

    assign data_out_a = regs[rd_slct_a];
    assign data_out_b = regs[rd_slct_b];

    always @(posedge clk) begin
        if (pre_we)      regs[pre_addr] <= pre_data;
        else if (wrtnbl) regs[wrt_slct[2:0]] <= data_in;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    // reference model: signed overflow from integer range, carry from integer magnitude
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  input logic [3:0] fl_in, output bit legal,
                                  output logic [7:0] res, output logic [3:0] fl);
        int ia, ib, sa, sb, full, s;
        bit c, v;
        ia = int'(a); ib = int'(b);
        sa = (ia >= 128) ? ia - 256 : ia;
        sb = (ib >= 128) ? ib - 256 : ib;
        c = 1'b0; v = 1'b0; legal = 1'b1; res = 8'h00;
        case (op)
            4'd0: begin full = ia + ib; res = 8'(full); c = full > 255;
                        s = sa + sb; v = (s > 127) || (s < -128); end
            4'd1: begin full = ia - ib; res = 8'(full); c = ia < ib;
                        s = sa - sb; v = (s > 127) || (s < -128); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ~a;
            4'd6: begin full = ia * 2; res = 8'(full); c = full > 255; end
            4'd7: begin res = 8'(ia / 2); c = (ia % 2) == 1; end
            4'd8: begin full = ia * ib; res = 8'(full); c = full > 255; end
            4'd9: res = a;
            default: legal = 1'b0;
        endcase
        fl = legal ? {res == 8'h00, res[7], c, v} : fl_in;
    endfunction

    task automatic preload(input logic [2:0] r, input logic [7:0] v);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = r; pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
        shadow[r] = v;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] dst,
                         input logic [2:0] sa, input logic [2:0] sb);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src_a = sa; cmd_src_b = sb;
    endtask

    // called away from the edge with a command on the bus; returns at the accept edge
    task automatic accept(input bit push);
        exp_t e;
        check("accept_ready", 32'(cmd_ready), 32'd1);
        if (push) begin
            model(cmd_op, shadow[cmd_src_a], shadow[cmd_src_b], exp_flags, e.legal, e.res, e.fl);
            e.dst = cmd_dst; e.sa = cmd_src_a; e.sb = cmd_src_b;
            e.wbk = (e.legal && cmd_op == 4'd8) ? 10 : 3;
            if (e.legal) shadow[cmd_dst] = e.res;
            exp_flags = e.fl;
            sbq.push_back(e);
        end
        @(posedge clk);
    endtask

    // walk cycles T+1..T+wbk after an accept, then the IDLE cycle that follows
    task automatic follow(input bit hold);
        exp_t e;
        if (sbq.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sbq[0];
        for (int k = 1; k <= e.wbk; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) cmd_valid = 1'b0;
            if (k == 1) begin
                check("rd_slct_a", 32'(rd_slct_a), 32'(e.sa));
                check("rd_slct_b", 32'(rd_slct_b), 32'(e.sb));
            end
            check("busy_ready", 32'(cmd_ready), 32'd0);
            check("wrtnbl", 32'(wrtnbl), 32'(k == e.wbk && e.legal));
            check("done", 32'(done), 32'(k == e.wbk));
            if (k == e.wbk) begin
                void'(sbq.pop_front());
                if (e.legal) begin
                    check("data_in", 32'(data_in), 32'(e.res));
                    check("wrt_slct", 32'(wrt_slct), {25'd0, 4'd0, e.dst});
                end
            end
        end
        @(negedge clk);
        check("idle_ready", 32'(cmd_ready), 32'd1);
        check("idle_done", 32'(done), 32'd0);
        check("flags", 32'(flags), 32'(e.fl));
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_dst = '0; cmd_src_a = '0;
        cmd_src_b = '0; pre_we = 1'b0; pre_addr = '0; pre_data = '0; exp_flags = 4'h0;
        #12;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_wrtnbl", 32'(wrtnbl), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_data_in", 32'(data_in), 32'd0);
        check("rst_wrt_slct", 32'(wrt_slct), 32'd0);
        check("rst_rd_slct", {26'd0, rd_slct_a, rd_slct_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(3'd0, 8'h00); preload(3'd1, 8'h7F); preload(3'd2, 8'h01); preload(3'd3, 8'h00);
        preload(3'd4, 8'h12); preload(3'd5, 8'h10); preload(3'd6, 8'h00); preload(3'd7, 8'h00);

        // ADD overflow into the sign bit
        drive(4'd0, 3'd3, 3'd1, 3'd2); accept(1'b1); follow(1'b0);
        check("t1_flags", 32'(flags), 32'h5);
        check("t1_r3", 32'(regs[3]), 32'h80);

        // SUB with borrow
        preload(3'd1, 8'h00); preload(3'd2, 8'h01);
        drive(4'd1, 3'd6, 3'd1, 3'd2); accept(1'b1); follow(1'b0);
        check("t2_flags", 32'(flags), 32'h6);
        check("t2_r6", 32'(regs[6]), 32'hFF);

        // multi-cycle MUL, destination aliases operand A
        drive(4'd8, 3'd4, 3'd4, 3'd5); accept(1'b1); follow(1'b0);
        check("t3_flags", 32'(flags), 32'h2);
        check("t3_r4", 32'(regs[4]), 32'h20);

        // back-to-back with valid held: second command sees the first write-back
        preload(3'd1, 8'h35);
        drive(4'd0, 3'd2, 3'd1, 3'd1); accept(1'b1);
        #1 cmd_op = 4'd9; cmd_dst = 3'd7; cmd_src_a = 3'd2; cmd_src_b = 3'd0;
        follow(1'b1);
        accept(1'b1); follow(1'b0);
        check("t4_r7", 32'(regs[7]), 32'h6A);

        // mixed ops, including src_a==src_b==dst and zero/carry cases
        for (int i = 0; i < 10; i++) begin
            drive(t_op[i], t_dst[i], t_sa[i], t_sb[i]); accept(1'b1); follow(1'b0);
            check("mix_reg", 32'(regs[t_dst[i]]), 32'(shadow[t_dst[i]]));
        end

        // illegal opcodes: done pulses, no write, flags held
        drive(4'hF, 3'd1, 3'd2, 3'd3); accept(1'b1); follow(1'b0);
        drive(4'hA, 3'd0, 3'd0, 3'd0); accept(1'b1); follow(1'b0);
        check("ill_r1", 32'(regs[1]), 32'(shadow[1]));

        // reset during MUL EXEC aborts with no write-back
        drive(4'd8, 3'd4, 3'd4, 3'd5); accept(1'b0);
        repeat (3) @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("abort_wrtnbl", 32'(wrtnbl), 32'd0);
        check("abort_flags", 32'(flags), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            check("abort_quiet", {30'd0, wrtnbl, done}, 32'd0);
        end
        check("abort_r4", 32'(regs[4]), 32'(shadow[4]));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
